// File: rtl/cycloneive_scan_muxn.sv
// Registered N-way channel mux with manual select and round-robin auto-scan
// over an enable mask, using a valid/ready output handshake.
module cycloneive_scan_muxn #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 clrn,
  input  logic                 ena,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH-1:0]       ch_en,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  output logic                 out_valid,
  output logic                 out_last
);

  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  scan_ch;
  logic [SELW-1:0]  hi_ch;
  logic [SELW-1:0]  cap_ch;
  logic [WIDTH-1:0] cap_data;
  logic             found;
  logic             accept;
  logic             stall;

  // NOTE: combinational logic uses blocking '=' with every output given a
  // default first, so no path leaves a value unassigned and no latch appears.
  always_comb begin
    scan_ch = ptr;
    found   = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      logic [SELW-1:0] idx;
      idx = ptr + SELW'(i);
      if (!found && ch_en[idx]) begin
        scan_ch = idx;
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    hi_ch = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ch_en[k]) hi_ch = SELW'(k);
    end
  end

  assign cap_ch   = mode ? scan_ch : sel;
  assign cap_data = in_data[int'(cap_ch)*WIDTH +: WIDTH];
  assign stall    = out_valid && !out_ready;
  assign accept   = ena && !stall && (!mode || (ch_en != '0));

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values and simulation order cannot change the result.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      out_data  <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (accept) begin
      out_data  <= cap_data;
      out_sel   <= cap_ch;
      out_valid <= 1'b1;
      out_last  <= mode && (scan_ch == hi_ch);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // A held sample freezes the pointer too; otherwise manual mode parks it at 0.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ptr <= '0;
    end else if (!stall) begin
      if (!mode)       ptr <= '0;
      else if (accept) ptr <= scan_ch + SELW'(1);
    end
  end

endmodule

// File: tb/tb_cycloneive_scan_muxn.sv
// Directed and randomized bench for cycloneive_scan_muxn against a
// behavioural model of the capture/scan rules.
module tb_cycloneive_scan_muxn;
  localparam int WIDTH = 8;
  localparam int NCH   = 4;
  localparam int SELW  = 2;

  logic                 clk = 1'b0;
  logic                 clrn;
  logic                 ena;
  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [NCH-1:0]       ch_en;
  logic [NCH*WIDTH-1:0] in_data;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_sel;
  logic                 out_valid;
  logic                 out_last;

  int checks = 0;
  int errors = 0;

  // model state
  int m_data, m_sel, m_valid, m_last, m_ptr;

  cycloneive_scan_muxn #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
    .clk(clk), .clrn(clrn), .ena(ena), .mode(mode), .sel(sel),
    .ch_en(ch_en), .in_data(in_data), .out_ready(out_ready),
    .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  function automatic int chan(input int k);
    return int'((in_data >> (k * WIDTH)) & {WIDTH{1'b1}});
  endfunction

  task automatic model_reset();
    m_data = 0; m_sel = 0; m_valid = 0; m_last = 0; m_ptr = 0;
  endtask

  task automatic model_step();
    bit held, acc;
    int c, hi;
    held = (m_valid == 1) && !out_ready;
    acc  = ena && !held && (!mode || ch_en != 0);
    c = -1;
    for (int i = 0; i < NCH; i++) begin
      int k;
      k = (m_ptr + i) % NCH;
      if (c < 0 && ch_en[k]) c = k;
    end
    hi = -1;
    for (int k = NCH - 1; k >= 0; k--) if (hi < 0 && ch_en[k]) hi = k;
    if (acc) begin
      if (!mode) begin
        m_data = chan(int'(sel)); m_sel = int'(sel); m_last = 0;
      end else begin
        m_data = chan(c); m_sel = c; m_last = (c == hi) ? 1 : 0;
      end
      m_valid = 1;
    end else if (out_ready) begin
      m_valid = 0;
    end
    if (!held) begin
      if (!mode) m_ptr = 0;
      else if (acc) m_ptr = (c + 1) % NCH;
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".data"},  int'(out_data),  m_data);
    check({tag, ".sel"},   int'(out_sel),   m_sel);
    check({tag, ".valid"}, int'(out_valid), m_valid);
    check({tag, ".last"},  int'(out_last),  m_last);
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    compare_model(tag);
  endtask

  initial begin
    int exp_sel[$];
    clrn = 1'b0; ena = 1'b0; mode = 1'b0; sel = '0; ch_en = '0;
    out_ready = 1'b1; in_data = 32'h33221100;
    model_reset();
    #12;
    check("rst.data",  int'(out_data),  0);
    check("rst.sel",   int'(out_sel),   0);
    check("rst.valid", int'(out_valid), 0);
    check("rst.last",  int'(out_last),  0);
    clrn = 1'b1;

    // manual mode
    ena = 1'b1;
    sel = 2'd2; tick("man0"); check("man0.k", int'(out_data), 'h22);
    sel = 2'd0; tick("man1"); check("man1.k", int'(out_data), 'h00);
    sel = 2'd3; tick("man2"); check("man2.k", int'(out_data), 'h33);
    check("man2.kv", int'(out_valid), 1);

    // full-mask scan
    mode = 1'b1; ch_en = 4'b1111;
    exp_sel = '{0, 1, 2, 3, 0, 1};
    foreach (exp_sel[i]) begin
      tick("full");
      check("full.ksel",  int'(out_sel),  exp_sel[i]);
      check("full.klast", int'(out_last), (exp_sel[i] == 3) ? 1 : 0);
    end

    // sparse mask, entered from manual so the scan restarts low
    mode = 1'b0; sel = 2'd0; tick("sp_entry");
    mode = 1'b1; ch_en = 4'b1010;
    exp_sel = '{1, 3, 1, 3};
    foreach (exp_sel[i]) begin
      tick("sparse");
      check("sparse.ksel",  int'(out_sel),  exp_sel[i]);
      check("sparse.kdata", int'(out_data), (exp_sel[i] == 3) ? 'h33 : 'h11);
      check("sparse.klast", int'(out_last), (exp_sel[i] == 3) ? 1 : 0);
    end

    // backpressure at channel 1
    ch_en = 4'b1111;
    tick("bp0"); check("bp0.ksel", int'(out_sel), 0);
    tick("bp1"); check("bp1.ksel", int'(out_sel), 1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sel = SELW'(i); ch_en = 4'(i + 3);
      tick("bp_hold");
      check("bp_hold.ksel",  int'(out_sel),  1);
      check("bp_hold.kdata", int'(out_data), 'h11);
    end
    ch_en = 4'b1111; out_ready = 1'b1;
    tick("bp_res"); check("bp_res.ksel", int'(out_sel), 2);
    tick("bp_res2"); check("bp_res2.ksel", int'(out_sel), 3);

    // empty mask drain
    ch_en = 4'b0000;
    tick("empty0"); check("empty0.kvalid", int'(out_valid), 0);
    tick("empty1");
    ch_en = 4'b0100;
    tick("empty2"); check("empty2.ksel", int'(out_sel), 2);
    check("empty2.kvalid", int'(out_valid), 1);

    // async reset mid-scan
    ch_en = 4'b1111;
    tick("pre_rst0"); tick("pre_rst1");
    #2 clrn = 1'b0;
    #1;
    model_reset();
    check("arst.data",  int'(out_data),  0);
    check("arst.sel",   int'(out_sel),   0);
    check("arst.valid", int'(out_valid), 0);
    check("arst.last",  int'(out_last),  0);
    clrn = 1'b1;
    tick("post_rst"); check("post_rst.ksel", int'(out_sel), 0);
    check("post_rst.kvalid", int'(out_valid), 1);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      ena       = ($urandom_range(0, 7) != 0);
      mode      = ($urandom_range(0, 5) != 0);
      sel       = SELW'($urandom);
      ch_en     = ($urandom_range(0, 7) == 0) ? 4'b0000 : NCH'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cycloneive_scan_muxn.md
CYCLONEIVE_SCAN_MUXN -- requirements
Module: cycloneive_scan_muxn

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the data bits per channel (1..64).
REQ-002 SHALL have parameter NCH, default 4, the channel count (2, 4, 8 or 16).
REQ-003 SHALL have parameter SELW, default 2, the select width; it SHALL equal log2(NCH).
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port clrn, input, 1 bit, the reset: asynchronous, active-low.
REQ-006 SHALL have port ena, input, 1 bit, the capture enable.
REQ-007 SHALL have port mode, input, 1 bit, the mode select: 0 = manual select, 1 = auto-scan.
REQ-008 SHALL have port sel, input, SELW bits, the manual channel select.
REQ-009 SHALL have port ch_en, input, NCH bits, the per-channel scan enable mask.
REQ-010 SHALL have port in_data, input, NCH*WIDTH bits; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-011 SHALL have port out_ready, input, 1 bit, the downstream ready.
REQ-012 SHALL have port out_data, output, WIDTH bits, the registered selected data.
REQ-013 SHALL have port out_sel, output, SELW bits, the channel index of the out_data sample.
REQ-014 SHALL have port out_valid, output, 1 bit, which qualifies out_data, out_sel and out_last.
REQ-015 SHALL have port out_last, output, 1 bit, set when the sample came from the highest-index enabled channel in scan mode.

Function
REQ-016 SHALL define accept = ena AND (NOT out_valid OR out_ready) AND (mode=0 OR ch_en != 0).
REQ-017 On accept with mode=0, SHALL register in_data[sel] to out_data and sel to out_sel, with out_valid=1 and out_last=0; latency 1 cycle from sel/in_data to outputs.
REQ-018 In scan mode, the capture channel c SHALL be the first channel with ch_en[c]=1 found searching circularly from scan pointer ptr upward (ptr itself included).
REQ-019 On accept with mode=1, SHALL register in_data[c] to out_data and c to out_sel, set out_valid=1, set out_last=1 if and only if c is the highest set bit of ch_en, and set ptr to (c+1) mod NCH.
REQ-020 ptr SHALL wrap from NCH-1 to 0 with no idle cycle.
REQ-021 ptr SHALL be forced to 0 on every cycle where mode=0, so each scan entry starts from the lowest enabled channel.
REQ-022 While out_valid=1 and out_ready=0, SHALL hold out_data, out_sel, out_last and ptr stable regardless of ena, sel, mode or ch_en.
REQ-023 When out_valid=1, out_ready=1 and accept=0, out_valid SHALL clear to 0 on the next edge and the other outputs SHALL hold their last values.
REQ-024 With mode=1 and ch_en=0, SHALL make no capture and leave ptr unchanged; out_valid SHALL drain per REQ-023.
REQ-025 A ch_en change SHALL take effect on the next accept; a disabled channel SHALL never be captured in scan mode.
REQ-026 When out_valid=1 and out_ready=1 and accept=1 in the same cycle, SHALL deliver back-to-back samples with no bubble: full throughput of 1 sample per cycle.
REQ-027 A mode change SHALL take effect on the next accept; a held sample SHALL not be altered.

Reset
REQ-028 While clrn=0, SHALL asynchronously force out_data=0, out_sel=0, out_valid=0, out_last=0 and ptr=0.
REQ-029 After clrn deassertion, SHALL make the first accept possible on the first rising edge of clk.
REQ-030 A reset mid-scan SHALL discard the held sample and restart the scan from channel 0.

Verification (WIDTH=8, NCH=4, in_data = {8'h33, 8'h22, 8'h11, 8'h00})
REQ-031 SHALL cover manual mode: mode=0, ena=1, out_ready=1, sel stepping 2,0,3 -> out_data 22,00,33 one cycle later, out_sel matching sel, out_valid held at 1.
REQ-032 SHALL cover a full-mask scan: mode=1, ch_en=4'b1111, out_ready=1 -> out_sel 0,1,2,3,0,... and out_last=1 only with out_sel=3.
REQ-033 SHALL cover a sparse mask: ch_en=4'b1010 -> out_sel 1,3,1,3 with out_data 11,33, and out_last=1 on every out_sel=3 sample.
REQ-034 SHALL cover backpressure: out_ready=0 for 3 cycles at out_sel=1 -> outputs frozen at 1/11 for those cycles, then the scan resumes at channel 2 with no channel skipped.
REQ-035 SHALL cover an empty mask and drain: ch_en=0, ena=1, out_ready=1 -> out_valid drops after 1 cycle; restoring ch_en=4'b0100 -> out_sel=2.
REQ-036 SHALL cover async reset: clrn pulsed low between clock edges mid-scan -> all outputs 0 immediately; after release, the first scan sample has out_sel=0.
